// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, FSM states and flag indices for the ALU sequencer
package alu_seq_pkg;

    localparam int WIDTH_DEF = 16;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_MUL  = 4'd8,
        OP_DIV  = 4'd9,
        OP_PASS = 4'd10
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    localparam int FLAG_C   = 0;
    localparam int FLAG_Z   = 1;
    localparam int FLAG_V   = 2;
    localparam int FLAG_ERR = 3;
    localparam int FLAG_N   = 4;

endpackage

// File: rtl/alu_seq_iter.sv
// rtl/alu_seq_iter.sv - iterative shift-add multiply / restoring divide datapath (divide under ALU_SEQ_DIV_EN)
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,     // load operands, begin WIDTH steps
    input  logic             abort,     // drop the in-flight op
    input  logic             is_div,    // 1: divide, 0: multiply
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,      // final step happens on this edge
    output logic [WIDTH-1:0] result,    // value after the final step
    output logic             overflow   // upper product half nonzero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // hi:lo is the product register (multiply) or remainder:quotient (divide)
    logic [WIDTH-1:0] hi, lo, b_q;
    logic [CW-1:0]    cnt;
    logic             busy_q;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic [WIDTH:0]   mul_sum;
    logic             div_sel;

`ifdef ALU_SEQ_DIV_EN
    logic             div_q;
    logic [WIDTH:0]   div_shift, div_trial;
    assign div_sel   = div_q;
    assign div_shift = {hi, lo[WIDTH-1]};
    // Remainder stays below b, so the borrow lands in the top bit of the trial
    assign div_trial = div_shift - {1'b0, b_q};
`else
    logic unused_is_div;
    assign unused_is_div = is_div;
    assign div_sel       = 1'b0;
`endif

    // Multiplier bits are consumed from lo[0]; the sum and lo shift right together
    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});

    always_comb begin
        hi_n = mul_sum[WIDTH:1];
        lo_n = {mul_sum[0], lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
        if (div_sel) begin
            hi_n = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], ~div_trial[WIDTH]};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            b_q    <= '0;
`ifdef ALU_SEQ_DIV_EN
            div_q  <= 1'b0;
`endif
        end else if (start) begin
            busy_q <= 1'b1;
            cnt    <= CW'(WIDTH - 1);
            hi     <= '0;
            lo     <= a;
            b_q    <= b;
`ifdef ALU_SEQ_DIV_EN
            div_q  <= is_div;
`endif
        end else if (abort) begin
            busy_q <= 1'b0;
        end else if (busy_q) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt - 1'b1;
            if (cnt == '0) busy_q <= 1'b0;
        end
    end

    assign busy     = busy_q;
    assign done     = busy_q && (cnt == '0);
    assign result   = lo_n;
    assign overflow = !div_sel && (hi_n != '0);

endmodule

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - ALU op sequencer/execute stage feeding the accumulator (divider under ALU_SEQ_DIV_EN)
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,   // request handshake
    output logic             in_ready,
    input  logic [OP_W-1:0]  opcode,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [WIDTH-1:0] acc_q,      // operand A, sampled at accept
    input  logic             flush,      // abort in-flight op
    output logic             res_valid,  // one-cycle result strobe
    output logic [WIDTH-1:0] res_data,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_err
);

    state_e              state;
    logic [WIDTH-1:0]    res_q;
    logic [FLAG_N-1:0]   flags_q;
    logic                valid_q;

    logic                accept;
    logic                is_multi;
    logic [WIDTH-1:0]    sc_res;
    logic [FLAG_N-1:0]   sc_flags;
    logic [FLAG_N-1:0]   it_flags;
    logic [WIDTH:0]      sum, diff;
    logic                it_busy, it_done, it_ovf;
    logic [WIDTH-1:0]    it_res;

    assign in_ready = (state == S_IDLE);
    // flush in IDLE suppresses the accept
    assign accept   = in_valid && in_ready && !flush;

    assign sum  = {1'b0, acc_q} + {1'b0, operand_b};
    assign diff = {1'b0, acc_q} - {1'b0, operand_b};

    always_comb begin
        sc_res   = acc_q;
        sc_flags = '0;
        is_multi = 1'b0;
        case (opcode)
            OP_ADD: begin
                sc_res           = sum[WIDTH-1:0];
                sc_flags[FLAG_C] = sum[WIDTH];
                sc_flags[FLAG_V] = (acc_q[WIDTH-1] == operand_b[WIDTH-1]) &&
                                   (sum[WIDTH-1] != acc_q[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res           = diff[WIDTH-1:0];
                sc_flags[FLAG_C] = diff[WIDTH];
                sc_flags[FLAG_V] = (acc_q[WIDTH-1] != operand_b[WIDTH-1]) &&
                                   (diff[WIDTH-1] != acc_q[WIDTH-1]);
            end
            OP_AND:  sc_res = acc_q & operand_b;
            OP_OR:   sc_res = acc_q | operand_b;
            OP_XOR:  sc_res = acc_q ^ operand_b;
            OP_NOT:  sc_res = ~acc_q;
            OP_SHL: begin
                sc_res           = {acc_q[WIDTH-2:0], 1'b0};
                sc_flags[FLAG_C] = acc_q[WIDTH-1];
            end
            OP_SHR: begin
                sc_res           = {1'b0, acc_q[WIDTH-1:1]};
                sc_flags[FLAG_C] = acc_q[0];
            end
            OP_MUL:  is_multi = 1'b1;
            OP_DIV: begin
`ifdef ALU_SEQ_DIV_EN
                if (operand_b == '0) begin
                    sc_res             = '1;
                    sc_flags[FLAG_ERR] = 1'b1;
                end else begin
                    is_multi = 1'b1;
                end
`else
                sc_res             = '0;
                sc_flags[FLAG_ERR] = 1'b1;
`endif
            end
            OP_PASS: sc_res = operand_b;
            default: sc_flags[FLAG_ERR] = 1'b1;
        endcase
        sc_flags[FLAG_Z] = (sc_res == '0);
    end

    always_comb begin
        it_flags         = '0;
        it_flags[FLAG_Z] = (it_res == '0);
        it_flags[FLAG_V] = it_ovf;
    end

    alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept && is_multi),
        .abort    (flush && (state == S_BUSY)),
        .is_div   (opcode == OP_DIV),
        .a        (acc_q),
        .b        (operand_b),
        .busy     (it_busy),
        .done     (it_done),
        .result   (it_res),
        .overflow (it_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            valid_q <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    valid_q <= 1'b0;
                    if (accept) begin
                        if (is_multi) begin
                            state <= S_BUSY;
                        end else begin
                            state   <= S_DONE;
                            valid_q <= 1'b1;
                            res_q   <= sc_res;
                            flags_q <= sc_flags;
                        end
                    end
                end
                S_BUSY: begin
                    valid_q <= 1'b0;
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (it_done) begin
                        state   <= S_DONE;
                        valid_q <= 1'b1;
                        res_q   <= it_res;
                        flags_q <= it_flags;
                    end else if (!it_busy) begin
                        // datapath lost its op; resynchronise rather than hang
                        state <= S_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign res_valid = valid_q;
    assign res_data  = res_q;
    assign flag_c    = flags_q[FLAG_C];
    assign flag_z    = flags_q[FLAG_Z];
    assign flag_v    = flags_q[FLAG_V];
    assign flag_err  = flags_q[FLAG_ERR];

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
Operation sequencer and execute stage directly upstream of the accumulator register.
- Accepts one opcode plus operand B per handshake and takes operand A from the accumulator's Q output.
- Runs single-cycle logic/arithmetic ops, or multi-cycle unsigned shift-add multiply and restoring divide.
- Presents a registered 16-bit result with a one-cycle valid strobe; the result feeds the accumulator's D input.

Parameters:
- WIDTH, 16, datapath width. MUL/DIV run for WIDTH iterations.
- OP_W, 4, opcode width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- opcode  in  OP_W  operation code; valid with in_valid.
- operand_b  in  WIDTH  B operand; valid with in_valid.
- acc_q  in  WIDTH  A operand from the accumulator output; sampled at accept.
- flush  in  1  synchronous abort of any in-flight op.
- res_valid  out  1  one-cycle pulse; res_data and the flags are valid.
- res_data  out  WIDTH  result, to the accumulator D input.
- flag_c  out  1  carry/borrow/shift-out.
- flag_z  out  1  res_data == 0.
- flag_v  out  1  signed overflow (ADD/SUB) or product overflow (MUL).
- flag_err  out  1  divide-by-zero or illegal opcode.

Behaviour:
- Reset (rst_n low, takes effect immediately): state=IDLE. res_valid, res_data, all flags, iteration counter and operand registers are 0. in_ready=1 once rst_n is high.
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB: A-B.
  - 2 AND, 3 OR, 4 XOR.
  - 5 NOT: ~A.
  - 6 SHL: A<<1; flag_c = A[15].
  - 7 SHR: logical A>>1; flag_c = A[0].
  - 8 MUL: unsigned, low WIDTH bits of the product.
  - 9 DIV: unsigned quotient A/B.
  - 10 PASS: result = B.
  - 11-15: illegal; res_data = A, flag_err=1.
- Accept: in_valid && in_ready on a rising edge. A, B and opcode are registered. No back-pressure on the result side.
- State machine:
  - IDLE: in_ready=1. On accept with a single-cycle op, compute and go to DONE. On accept with MUL, or DIV with B!=0, go to BUSY with counter=WIDTH-1.
  - BUSY: in_ready=0. One shift-add or restore-subtract step per cycle. When counter==0, go to DONE.
  - DONE: in_ready=0. res_valid=1 for exactly this cycle. Go to IDLE.
- Latency, counted from the accept edge T:
  - Single-cycle ops: res_valid high in cycle T+1.
  - MUL/DIV: res_valid high in cycle T+WIDTH+1.
  - Peak throughput: one op per 2 cycles.
- res_data and the flags hold their value after the DONE cycle until the next DONE cycle.
- Flags:
  - ADD: flag_c = carry-out; flag_v = (A[15]==B[15]) && (R[15]!=A[15]).
  - SUB: flag_c = borrow (A<B unsigned); flag_v = (A[15]!=B[15]) && (R[15]!=A[15]).
  - MUL: flag_v = 1 if the upper WIDTH product bits are nonzero.
  - Any flag not defined for an op is 0.
- DIV with B==0: takes the single-cycle path; res_data=16'hFFFF, flag_err=1.
- flush:
  - In BUSY: return to IDLE next edge. No res_valid; outputs keep their previous values.
  - In DONE: the pulse still completes.
  - In IDLE: flush wins over a simultaneous accept; nothing is accepted.
- Reset asserted mid-BUSY: op is discarded and no res_valid is produced.
- acc_q changing during BUSY has no effect, because A is captured at accept.

Optional Feature:
Macro: ALU_SEQ_DIV_EN.
- Defined: DIV is implemented as above.
- Undefined: no divider logic. Opcode 9 is handled as illegal and single-cycle: res_data=0, flag_err=1, res_valid at T+1.

Decomposition:
- Package alu_seq_pkg:
  - WIDTH_DEF=16.
  - Opcode enum (OP_ADD..OP_PASS).
  - State enum (S_IDLE, S_BUSY, S_DONE).
  - Flag bit-index constants.
- Sub-module alu_seq_iter: the iterative multiply/divide datapath, with start, is_div, A and B in; busy, done, result and overflow out. The divide path is guarded by ALU_SEQ_DIV_EN.
- The FSM, the single-cycle ops and the flag logic stay in alu_seq_core.

Test Plan:
- Reset, then ADD A=16'h7FFF, B=16'h0001: res_data=16'h8000, flag_v=1, flag_c=0, flag_z=0, res_valid high at T+1 only.
- SUB A=16'h0003, B=16'h0005: res_data=16'hFFFE, flag_c=1, flag_v=0. Immediately follow with PASS B=16'h1234: in_ready=0 in the DONE cycle; second result 16'h1234.
- MUL A=16'h0100, B=16'h0100: res_data=16'h0000, flag_z=1, flag_v=1, res_valid at T+17. MUL A=16'h00FF, B=16'h0003: 16'h02FD, flag_v=0.
- DIV A=100, B=7: res_data=14 at T+17. DIV A=5, B=0: 16'hFFFF, flag_err=1 at T+1. Without ALU_SEQ_DIV_EN, DIV A=100, B=7: res_data=0, flag_err=1 at T+1.
- Start MUL, assert flush at T+5: no res_valid, in_ready=1 at T+6. A new ADD 2+3 is accepted and yields 5.
- Start DIV, drop rst_n at T+8: all outputs 0 immediately. After release, no stray res_valid; opcode 4'hC gives res_data=A, flag_err=1.
